serial_alu_seq: RTL
===================

# serial_alu_seq

Bit-serial ALU sequencer for the serial datapath. It accepts two WIDTH-bit operands and a 3-bit operation code, then streams the operands LSB-first, one bit per clock. It drives the current op2 bit and the held opsel to the downstream B-operand mux, consumes that mux's B output, and resolves each bit in an internal full-adder and carry register. On completion it reports the result, carry and zero flags.

## Interface
- WIDTH, 8: operand/result width in bits; legal range WIDTH >= 2.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_code  in  3  operation; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- op2  out  1  current B-operand bit to the B mux (b_sr[0])
- opsel  out  3  registered op_code to the B mux; held for the whole operation
- B  in  1  selected B bit returned from the B mux; combinational from op2/opsel within the same cycle
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  last completed result
- carry  out  1  final carry of last completed operation
- zero  out  1  high when result == 0
- err  out  1  one-cycle pulse on an illegal op_code

## Operation
- Opcodes (B-mux selection / carry-in):
  - 000 ADD: op2 / 0
  - 001 SUB: ~op2 / 1
  - 010 PASS A: 0 / 0
  - 011 A+~B: ~op2 / 0, giving A-B-1
  - 100 INC: 0 / 1
  - 101 DEC: 1 / 0
  - 110 ADDC: op2 / carry flag
  - 111 illegal
- For SUB, carry=1 means no borrow.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 with a legal op_code:
  - load a_sr<=a, b_sr<=b, opsel<=op_code, c<=cin, cnt<=0
  - go to RUN
- IDLE, start=1 with op_code 111:
  - stay in IDLE and pulse err for one cycle
  - no other register changes
- RUN, each cycle:
  - s = a_sr[0]^B^c
  - c <= maj(a_sr[0],B,c)
  - r_sr <= {s, r_sr[WIDTH-1:1]}
  - a_sr and b_sr shift right by 1
  - cnt++
- RUN exit: the cycle with cnt==WIDTH-1 loads result<={s, r_sr[WIDTH-1:1]}, carry<=final carry, zero<=(that value==0), then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored and not queued.
- carry, zero and result change only on the RUN->DONE transition.
- ADDC uses the carry flag left by the previous completed operation.
- Counter width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH.

## Timing
- Reset values:
  - state=IDLE
  - busy, done, err, carry, zero = 0; result=0
  - opsel=000, op2=0
  - all shift registers, c and cnt = 0
- Reset mid-operation aborts immediately: no done pulse, flags cleared.
- Latency: start sampled at edge E0 → RUN during cycles E0..E0+WIDTH-1 → done high in the cycle after edge E0+WIDTH.
- Back-to-back: the earliest next start is sampled at the edge that leaves DONE+1 (IDLE), so throughput is one operation per WIDTH+2 cycles.
- err is high in the cycle following the sampling edge.
- op2 and opsel are register outputs with no combinational path from inputs. B must settle within the same cycle.

## Test plan
Bench includes a behavioural B-mux model matching the selection table above. All values are for WIDTH=8.
- ADD a=0x3C, b=0x05 → result=0x41, carry=0, zero=0. done is exactly 9 cycles after the start edge and busy is high for 9 cycles.
- SUB: a=0x06, b=0x05 → 0x01, carry=1. Then a=0x05, b=0x06 → 0xFF, carry=0.
- ADD 0xFF+0x01 → 0x00, carry=1, zero=1. Then ADDC a=0x00, b=0x00 → 0x01, carry=0.
- INC a=0xFF → 0x00, carry=1, zero=1. DEC a=0x00 → 0xFF, carry=0. PASS a=0xA5 → 0xA5. op 011 with a=0x10, b=0x01 → 0x0E.
- op_code=111 → err pulses once, busy stays 0, result/flags unchanged. start held high during RUN → no second operation starts.
- rst asserted at RUN cycle 4 → busy=0 and result/carry/zero=0 asynchronously, no done pulse. A subsequent ADD 0x01+0x01 → 0x02.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams two operands LSB-first through an external
// B-operand mux and an internal full adder, one bit per clock.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             op2,
  output logic [2:0]       opsel,
  input  logic             B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [2:0]       opsel_q, opsel_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic sum_bit;
  logic carry_out;
  logic cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      opsel_q  <= 3'b000;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      opsel_q  <= opsel_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Carry-in seeds the serial adder; ADDC chains the previous completed carry.
  always_comb begin
    cin = 1'b0;
    case (op_code)
      3'b001:  cin = 1'b1;
      3'b100:  cin = 1'b1;
      3'b110:  cin = carry_q;
      default: cin = 1'b0;
    endcase
  end

  assign sum_bit   = a_sr_q[0] ^ B ^ c_q;
  assign carry_out = (a_sr_q[0] & B) | (a_sr_q[0] & c_q) | (B & c_q);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    opsel_d  = opsel_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_code == 3'b111) begin
            err_d = 1'b1;
          end else begin
            a_sr_d  = a;
            b_sr_d  = b;
            opsel_d = op_code;
            c_d     = cin;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        c_d    = carry_out;
        r_sr_d = {sum_bit, r_sr_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Flags are published only here so they stay stable between operations.
        if (cnt_q == LAST) begin
          result_d = {sum_bit, r_sr_q[WIDTH-1:1]};
          carry_d  = carry_out;
          zero_d   = ({sum_bit, r_sr_q[WIDTH-1:1]} == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign op2    = b_sr_q[0];
  assign opsel  = opsel_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule
